// File: rtl/tdc_pd_param.sv
// Bang-bang/linear TDC phase detector: measures clk_ref vs fb_clk skew in clk cycles.
// Optional thermometer output enabled by TDC_PD_THERM_OUT_EN.
module tdc_pd_param #(
  parameter int CNT_W       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clk_ref,
  input  logic             fb_clk,
  output logic [CNT_W-1:0] err_mag,
  output logic             err_sign,
  output logic             err_valid,
  output logic             err_sat,
`ifdef TDC_PD_THERM_OUT_EN
  output logic             slip,
  output logic [(2**CNT_W)-2:0] therm
`else
  output logic             slip
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WFB   = 2'd1;
  localparam logic [1:0] S_WREF  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] ref_sync;
  logic [SYNC_STAGES-1:0] fb_sync;
  logic                   ref_d;
  logic                   fb_d;
  logic                   ref_edge;
  logic                   fb_edge;

  logic                   armed;
  logic [1:0]             state;
  logic [1:0]             state_n;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;
  logic [CNT_W-1:0]       cnt_inc;

  logic                   res;
  logic [CNT_W-1:0]       res_mag;
  logic                   res_sign;
  logic                   res_sat;
  logic                   slip_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_d    <= 1'b0;
      fb_d     <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], clk_ref};
      fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_clk};
      ref_d    <= ref_sync[SYNC_STAGES-1];
      fb_d     <= fb_sync[SYNC_STAGES-1];
    end
  end

  assign ref_edge = ref_sync[SYNC_STAGES-1] & ~ref_d;
  assign fb_edge  = fb_sync[SYNC_STAGES-1] & ~fb_d;

  // Count value k in a WAIT state means k cycles since the leading detect.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    res      = 1'b0;
    res_mag  = cnt;
    res_sign = 1'b0;
    slip_n   = 1'b0;
    if (!en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (1'b1)
        (state == S_WFB): begin
          if (fb_edge) begin
            res      = 1'b1;
            res_sign = 1'b1;
            state_n  = S_IDLE;
            cnt_n    = '0;
          end else if (ref_edge) begin
            cnt_n  = CNT_ONE;
            slip_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        (state == S_WREF): begin
          if (ref_edge) begin
            res     = 1'b1;
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (fb_edge) begin
            cnt_n  = CNT_ONE;
            slip_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          // A ref edge arms the block and may start a measurement in the same cycle.
          if (ref_edge && fb_edge) begin
            res     = 1'b1;
            res_mag = '0;
          end else if (ref_edge) begin
            state_n = S_WFB;
            cnt_n   = CNT_ONE;
          end else if (fb_edge && armed) begin
            state_n = S_WREF;
            cnt_n   = CNT_ONE;
          end
        end
      endcase
    end
    res_sat = (res_mag == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      if (ref_edge) armed <= 1'b1;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_mag   <= '0;
      err_sign  <= 1'b0;
      err_sat   <= 1'b0;
      err_valid <= 1'b0;
      slip      <= 1'b0;
    end else begin
      err_valid <= res;
      slip      <= slip_n;
      if (res) begin
        err_mag  <= res_mag;
        err_sign <= res_sign;
        err_sat  <= res_sat;
      end
    end
  end

`ifdef TDC_PD_THERM_OUT_EN
  localparam int TW = (2**CNT_W) - 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      therm <= '0;
    end else if (res) begin
      therm <= ~({TW{1'b1}} << res_mag);
    end
  end
`endif

endmodule

// File: tb/tb_tdc_pd_param.sv
// Scoreboard bench for tdc_pd_param (CNT_W=5, SYNC_STAGES=2).
// Expected results are queued at stimulus time and popped on err_valid.
module tb_tdc_pd_param;

  typedef struct packed {
    logic [4:0] mag;
    logic       sign;
    logic       sat;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       clk_ref = 1'b0;
  logic       fb_clk = 1'b0;
  logic [4:0] err_mag;
  logic       err_sign;
  logic       err_valid;
  logic       err_sat;
  logic       slip;
`ifdef TDC_PD_THERM_OUT_EN
  logic [30:0] therm;
`endif

  int   total = 0;
  int   bad = 0;
  int   slip_seen = 0;
  res_t sb[$];

  tdc_pd_param #(.CNT_W(5), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clk_ref   (clk_ref),
    .fb_clk    (fb_clk),
    .err_mag   (err_mag),
    .err_sign  (err_sign),
    .err_valid (err_valid),
    .err_sat   (err_sat),
`ifdef TDC_PD_THERM_OUT_EN
    .slip      (slip),
    .therm     (therm)
`else
    .slip      (slip)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] th(input int m);
    logic [30:0] v;
    for (int i = 0; i < 31; i++) v[i] = (i < m);
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset && slip) slip_seen++;
    if (reset && err_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("err_mag", err_mag, e.mag);
        chk("err_sign", err_sign, e.sign);
        chk("err_sat", err_sat, e.sat);
`ifdef TDC_PD_THERM_OUT_EN
        chk("therm", therm, th(int'(e.mag)));
`endif
      end
    end
  end

  function automatic logic hit(input int t, input int s);
    return (s >= 0) && (t >= s) && (t < s + 2);
  endfunction

  // Drive 2-cycle-wide pin pulses starting at the given cycle offsets.
  task automatic run(input int r0, input int r1, input int f0, input int len);
    for (int t = 0; t < len; t++) begin
      clk_ref = hit(t, r0) || hit(t, r1);
      fb_clk  = hit(t, f0);
      @(negedge clk);
    end
    clk_ref = 1'b0;
    fb_clk  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic push(input int m, input logic s, input logic st);
    res_t e;
    e.mag  = 5'(m);
    e.sign = s;
    e.sat  = st;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mag", err_mag, 0);
    chk("rst_sign", err_sign, 0);
    chk("rst_valid", err_valid, 0);
    chk("rst_sat", err_sat, 0);
    chk("rst_slip", slip, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    push(7, 1'b1, 1'b0);
    run(0, -1, 7, 12);
    drain();

    push(3, 1'b0, 1'b0);
    run(3, -1, 0, 8);
    drain();

    push(31, 1'b1, 1'b1);
    run(0, -1, 40, 45);
    drain();

    push(5, 1'b1, 1'b0);
    run(0, 4, 9, 14);
    drain();
    chk("slip_once", slip_seen, 1);

    push(0, 1'b0, 1'b0);
    run(0, -1, 0, 5);
    drain();

    push(31, 1'b1, 1'b1);
    run(0, -1, 31, 36);
    drain();

    push(30, 1'b1, 1'b0);
    run(0, -1, 30, 35);
    drain();

    push(6, 1'b1, 1'b0);
    run(0, 6, 6, 10);
    drain();
    chk("slip_none_both", slip_seen, 1);

    en = 1'b0;
    run(0, -1, 3, 8);
    repeat (6) @(negedge clk);
    en = 1'b1;
    drain();

    push(2, 1'b0, 1'b0);
    run(2, -1, 0, 6);
    drain();

    run(0, -1, -1, 5);
    #2 reset = 1'b0;
    #1;
    chk("arst_mag", err_mag, 0);
    chk("arst_sign", err_sign, 0);
    chk("arst_sat", err_sat, 0);
    chk("arst_valid", err_valid, 0);
    chk("arst_slip", slip, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(-1, -1, 0, 6);
    drain();

    push(2, 1'b1, 1'b0);
    run(0, -1, 2, 6);
    drain();
    chk("slip_final", slip_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
